data_mem_param: RTL
===================

# data_mem_param

Parametrised successor to the 16-entry register data memory. It holds a DEPTH×DATA_W flop-based array with per-byte write enables, a registered read port with a valid strobe, and a sequential clear engine that zeroes the array one entry per cycle. It sits on the datapath's memory stage, driven by the MemRead/MemWrite controls from the control unit.

## Interface
Parameters:
- DATA_W, 16, word width in bits; must be a multiple of 8.
- ADDR_W, 4, address width in bits; DEPTH = 2**ADDR_W entries.
- BE_W, DATA_W/8, number of byte enables (derived; do not override).

Ports:
- clk, in, 1, single clock; all state changes on the rising edge.
- rst, in, 1, reset, asynchronous, active-high.
- addr, in, ADDR_W, word address for read or write.
- data_in, in, DATA_W, write data.
- byte_en, in, BE_W, per-byte write enable; bit i covers data_in[8i+7:8i].
- MemWrite, in, 1, write request.
- MemRead, in, 1, read request.
- clear, in, 1, start a full-array clear; sampled only when idle.
- ready, out, 1, high when requests are accepted (IDLE state).
- busy, out, 1, high while the clear engine runs; always equals ~ready.
- data_out, out, DATA_W, read data; zero whenever rd_valid is low.
- rd_valid, out, 1, one-cycle strobe marking valid data_out.

## Operation
- FSM states: IDLE and CLEAR. Reset state is IDLE.
- IDLE → CLEAR when clear=1 at a rising edge. CLEAR → IDLE on the edge that zeroes entry DEPTH-1.
- Write: if MemWrite=1 and ready=1 at an edge, then for each i with byte_en[i]=1, mem[addr] byte i ← data_in byte i. Other bytes are unchanged. byte_en=0 means no change.
- Read: if MemRead=1 and ready=1 at an edge, data_out ← mem[addr] as it was before that edge, and rd_valid ← 1 for exactly one cycle. Otherwise rd_valid ← 0 and data_out ← 0.
- Read and write in the same cycle, same address: the read returns the old contents (read-before-write), and the write still commits.
- Read and write in the same cycle, different addresses: both complete.
- clear together with MemRead/MemWrite in IDLE: clear wins. The request is dropped (no write, rd_valid stays 0).
- In CLEAR: MemRead, MemWrite and clear are all ignored. A clear counter walks addresses 0..DEPTH-1 and writes zero to one full word per edge.
- Reset (any time, including mid-clear):
  - every array entry = 0, data_out = 0, rd_valid = 0
  - state = IDLE, clear counter = 0, ready = 1, busy = 0
- Addresses are full-range (DEPTH = 2**ADDR_W), so there is no out-of-range case.
- The clear counter is ADDR_W bits wide. It terminates on reaching DEPTH-1 rather than wrapping.

## Timing
- Write latency: data is visible to a read issued on the following edge (one cycle).
- Read latency: one cycle. A request sampled at edge k gives data_out/rd_valid valid from after edge k until edge k+1.
- Back-to-back reads: one per cycle, so rd_valid stays high continuously.
- Clear sequence, with clear sampled at edge k:
  - busy=1 and ready=0 from after edge k until after edge k+DEPTH.
  - Entry i is zeroed at edge k+1+i.
  - Total clear duration is DEPTH cycles. The first request is accepted at edge k+DEPTH+1.
- ready and busy are registered state decodes, not combinational paths from inputs.
- There are no combinational paths from inputs to outputs.

## Test plan
- Reset then read: assert rst, release, then read addr 0..15. Required: every data_out = 0x0000, and rd_valid pulses one cycle per read.
- Byte-enable write: write 0xABCD with byte_en=11 to addr 5, then write 0x1234 with byte_en=01 to addr 5, then read addr 5. Required: 0xAB34.
- Same-cycle read and write: mem[3]=0x1111; issue MemRead+MemWrite to addr 3 with 0x2222 in one cycle. Required: data_out=0x1111. A following read returns 0x2222.
- Clear sweep: fill all 16 entries with 0xFFFF, then pulse clear together with a write to addr 2.
  - busy must be high for exactly 16 cycles.
  - Writes and reads issued during busy must have no effect (rd_valid=0).
  - All entries read back 0x0000, including addr 2.
- Reset mid-clear: assert rst asynchronously (between edges) 5 cycles into a clear. Required: busy=0 and ready=1 immediately, and the full array reads zero.
- Parametrisation: instantiate with DATA_W=32, ADDR_W=6 and repeat the byte-enable and clear tests. Required: the clear takes 64 cycles, and a 4-bit byte_en merge is correct (e.g. 0xDEADBEEF merged with 0x00000011 using byte_en=0001 gives 0xDEADBE11).

Source files
------------

// File: rtl/data_mem_param.sv
// Parametrised flop-based data memory: per-byte write enables, registered read
// port with a one-cycle valid strobe, and a sequential one-entry-per-cycle clear engine.
module data_mem_param #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic [BE_W-1:0]   byte_en,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic              clear,
  output logic              ready,
  output logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]        state_r;
  logic [0:0]        state_nxt_s;
  logic [ADDR_W-1:0] clr_cnt_r;
  logic              clr_last_s;
  logic              accept_s;
  logic              wr_en_s;
  logic              rd_en_s;
  logic              ready_r;
  logic              busy_r;
  logic              rd_valid_r;
  logic [DATA_W-1:0] data_out_r;
  logic [DATA_W-1:0] mem_r [DEPTH];

  // Requests are only honoured while idle, and a clear pre-empts them.
  assign clr_last_s = (clr_cnt_r == ADDR_W'(DEPTH - 1));
  assign accept_s   = (state_r == ST_IDLE) && !clear;
  assign wr_en_s    = accept_s && MemWrite;
  assign rd_en_s    = accept_s && MemRead;

  // Next-state decode for the idle/clear controller.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (clear) begin
          state_nxt_s = ST_CLEAR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (clr_last_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, clear counter and the registered ready/busy decodes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      clr_cnt_r <= '0;
      ready_r   <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s == ST_IDLE);
      busy_r  <= (state_nxt_s == ST_CLEAR);
      if (state_r == ST_CLEAR) begin
        clr_cnt_r <= clr_last_s ? '0 : clr_cnt_r + ADDR_W'(1);
      end else begin
        clr_cnt_r <= '0;
      end
    end
  end

  // Storage array: byte-masked writes when idle, one full word zeroed per clear cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (state_r == ST_CLEAR) begin
      mem_r[clr_cnt_r] <= '0;
    end else if (wr_en_s) begin
      for (int b = 0; b < BE_W; b++) begin
        if (byte_en[b]) begin
          mem_r[addr][8*b +: 8] <= data_in[8*b +: 8];
        end
      end
    end
  end

  // Read port samples the pre-edge contents, giving read-before-write on a collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_r <= '0;
      rd_valid_r <= 1'b0;
    end else begin
      data_out_r <= rd_en_s ? mem_r[addr] : '0;
      rd_valid_r <= rd_en_s;
    end
  end

  assign ready    = ready_r;
  assign busy     = busy_r;
  assign data_out = data_out_r;
  assign rd_valid = rd_valid_r;

endmodule
